// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - sizing helpers and shared types for the bank controller
// Contents: ROW_W/BYTES sizing functions, response buffer depth, row and grant types.
package mem_ctrl_pkg;

   localparam int DEF_SIZE  = 7;
   localparam int RSP_DEPTH = 2;

   // Row address width for a 4 KiB bank split into 2**size-byte rows.
   function automatic int ROW_W(input int size);
      return 12 - size;
   endfunction

   // Bytes per row.
   function automatic int BYTES(input int size);
      return 1 << size;
   endfunction

   typedef logic [ROW_W(DEF_SIZE)-1:0] row_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2
   } gnt_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - in-order read response buffer, head data always visible
// Ports: clk/rst (sync, active-high); push/push_data in; pop in;
//        cnt (occupancy), not_empty, head_data out.
module mem_rsp_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   cnt,
   output logic         not_empty,
   output logic [W-1:0] head_data
);

   logic [W-1:0] mem_q [RSP_DEPTH];
   logic [W-1:0] mem_d [RSP_DEPTH];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push, do_pop;

   // Pointers are single bits that toggle, which only works for a depth of 2.
   always_comb begin
      do_pop   = pop && (cnt_q != 2'd0);
      // A push into a full buffer is only legal when the head leaves this cycle.
      do_push  = push && ((cnt_q != 2'(RSP_DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cnt       = cnt_q;
   assign not_empty = (cnt_q != 2'd0);
   assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_bank_ctrl.sv
// rtl/mem_bank_ctrl.sv - round-robin write/read arbiter in front of a single-port bank
// Ports: clk/rst (sync, active-high); write request wr_* and completion b_*;
//        read request rd_* and response rsp_*; bank side mem_* (registered mem_rdata).
module mem_bank_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int SIZE = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ROW_W(SIZE)-1:0]    wr_addr,
   input  logic [BYTES(SIZE)*8-1:0]  wr_data,
   input  logic [BYTES(SIZE)-1:0]    wr_strb,
   output logic                      b_valid,
   input  logic                      b_ready,
   input  logic                      rd_valid,
   output logic                      rd_ready,
   input  logic [ROW_W(SIZE)-1:0]    rd_addr,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [BYTES(SIZE)*8-1:0]  rsp_data,
   output logic                      mem_cs,
   output logic                      mem_we,
   output logic [ROW_W(SIZE)-1:0]    mem_row_addr,
   output logic [BYTES(SIZE)*8-1:0]  mem_wdata,
   output logic [BYTES(SIZE)-1:0]    mem_wstrb,
   input  logic [BYTES(SIZE)*8-1:0]  mem_rdata
);

   localparam int RW = ROW_W(SIZE);
   localparam int DW = BYTES(SIZE) * 8;

   gnt_e          gnt;
   logic          wr_elig, rd_elig, pop;
   logic [1:0]    fifo_cnt;
   logic [2:0]    rd_occ;
   logic          pend_q, pend_d;
   logic          b_valid_q, b_valid_d;
   logic          last_wr_q, last_wr_d;
   logic [RW-1:0] row_q, row_d;
   logic [DW-1:0] wdata_q, wdata_d;

   // Eligibility and arbitration. A read in flight (pend) already owns a
   // buffer slot, and a slot freed by this cycle's pop can be reused at once.
   always_comb begin
      pop     = rsp_valid && rsp_ready;
      rd_occ  = 3'(fifo_cnt) + 3'(pend_q) - 3'(pop);
      wr_elig = !rst && wr_valid && (!b_valid_q || b_ready);
      rd_elig = !rst && rd_valid && (rd_occ < 3'd2);
      gnt     = GNT_NONE;
      if (wr_elig && rd_elig) begin
         gnt = last_wr_q ? GNT_RD : GNT_WR;
      end else if (wr_elig) begin
         gnt = GNT_WR;
      end else if (rd_elig) begin
         gnt = GNT_RD;
      end
   end

   // Next state. The bank address and write data hold through idle cycles,
   // and reads leave the write data untouched.
   always_comb begin
      pend_d    = (gnt == GNT_RD);
      last_wr_d = last_wr_q;
      b_valid_d = b_valid_q;
      row_d     = row_q;
      wdata_d   = wdata_q;
      if (gnt == GNT_WR) begin
         last_wr_d = 1'b1;
         b_valid_d = 1'b1;
         row_d     = wr_addr;
         wdata_d   = wr_data;
      end else begin
         if (b_ready) begin
            b_valid_d = 1'b0;
         end
         if (gnt == GNT_RD) begin
            last_wr_d = 1'b0;
            row_d     = rd_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= 1'b0;
         last_wr_q <= 1'b0;
         b_valid_q <= 1'b0;
         row_q     <= '0;
         wdata_q   <= '0;
      end else begin
         pend_q    <= pend_d;
         last_wr_q <= last_wr_d;
         b_valid_q <= b_valid_d;
         row_q     <= row_d;
         wdata_q   <= wdata_d;
      end
   end

   // Outputs. Chip select stays high whenever out of reset so the bank keeps
   // driving mem_rdata; only the strobes decide whether anything is written.
   always_comb begin
      wr_ready     = (gnt == GNT_WR);
      rd_ready     = (gnt == GNT_RD);
      mem_cs       = !rst;
      mem_we       = wr_ready;
      mem_wstrb    = wr_ready ? wr_strb : '0;
      mem_row_addr = row_d;
      mem_wdata    = wdata_d;
      b_valid      = b_valid_q;
   end

   // Bank data for a read issued last cycle is captured here.
   mem_rsp_fifo #(
      .W (DW)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pend_q),
      .push_data (mem_rdata),
      .pop       (pop),
      .cnt       (fifo_cnt),
      .not_empty (rsp_valid),
      .head_data (rsp_data)
   );

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb/tb_mem_bank_ctrl.sv - directed self-checking bench for mem_bank_ctrl
module tb_mem_bank_ctrl;
   import mem_ctrl_pkg::*;

   localparam int SIZE = 7;
   localparam int RW   = ROW_W(SIZE);
   localparam int NB   = BYTES(SIZE);
   localparam int DW   = NB * 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid, wr_ready;
   logic [RW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [NB-1:0] wr_strb;
   logic          b_valid, b_ready;
   logic          rd_valid, rd_ready;
   logic [RW-1:0] rd_addr;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          mem_cs, mem_we;
   logic [RW-1:0] mem_row_addr;
   logic [DW-1:0] mem_wdata;
   logic [NB-1:0] mem_wstrb;
   logic [DW-1:0] mem_rdata = '0;

   logic [DW-1:0] bank [2**RW] = '{default: '0};

   int errors = 0;
   int checks = 0;

   mem_bank_ctrl #(.SIZE(SIZE)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_strb      (wr_strb),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_addr      (rd_addr),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .mem_cs       (mem_cs),
      .mem_we       (mem_we),
      .mem_row_addr (mem_row_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // Bank: byte writes under strobe and chip select, registered read of the old row.
   always @(posedge clk) begin
      if (mem_cs) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_wstrb[i]) bank[mem_row_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
         end
         mem_rdata <= bank[mem_row_addr];
      end
   end

   function automatic logic [DW-1:0] fill(input logic [7:0] b);
      return {NB{b}};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_row(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, obs[63:0], exp[63:0]);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] row3_exp;

   initial begin
      row3_exp       = '0;
      row3_exp[7:0]  = 8'hFF;

      // Reset held 3 cycles with both requests asserted.
      rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; b_ready = 1'b1; rsp_ready = 1'b1;
      wr_addr = 7; wr_data = fill(8'h11); wr_strb = '1; rd_addr = 7;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("rst_wr_ready", wr_ready, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_wstrb", mem_wstrb, 0);
      end
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk_row("rst_rsp_data", rsp_data, '0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_row_addr", mem_row_addr, 0);
      chk_row("rst_mem_wdata", mem_wdata, '0);
      rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
      #1;
      chk("cs_after_rst", mem_cs, 1);
      chk_row("no_write_in_rst", bank[7], '0);

      // Write row 5 with 0xA5, then read it back.
      cyc();
      wr_valid = 1'b1; wr_addr = 5; wr_data = fill(8'hA5); wr_strb = '1;
      #1;
      chk("w5_wr_ready", wr_ready, 1);
      chk("w5_mem_we", mem_we, 1);
      chk("w5_row_addr", mem_row_addr, 5);
      chk("w5_wstrb", mem_wstrb, {NB{1'b1}});
      cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5;
      #1;
      chk("w5_b_valid_t1", b_valid, 1);
      chk("r5_rd_ready", rd_ready, 1);
      chk("r5_mem_we", mem_we, 0);
      chk("r5_wstrb", mem_wstrb, 0);
      cyc();
      rd_valid = 1'b0;
      #1;
      chk("r5_rsp_valid_t1", rsp_valid, 0);
      chk("w5_b_valid_clr", b_valid, 0);
      chk("idle_row_hold", mem_row_addr, 5);
      chk_row("idle_wdata_hold", mem_wdata, fill(8'hA5));
      cyc();
      chk("r5_rsp_valid_t2", rsp_valid, 1);
      chk_row("r5_rsp_data", rsp_data, fill(8'hA5));
      cyc();
      chk("r5_drained", rsp_valid, 0);

      // Both requesters valid for 6 cycles: strict alternation, write first.
      wr_valid = 1'b1; wr_addr = 10; wr_data = fill(8'h3C); wr_strb = '1;
      rd_valid = 1'b1; rd_addr = 5;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("alt_wr_ready", wr_ready, (i % 2 == 0));
         chk("alt_rd_ready", rd_ready, (i % 2 == 1));
         chk("alt_mem_we", mem_we, (i % 2 == 0));
         if (i == 3) chk_row("alt_rsp_data", rsp_data, fill(8'hA5));
         cyc();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      cyc(); cyc(); cyc();
      chk("alt_rsp_empty", rsp_valid, 0);
      chk("alt_b_empty", b_valid, 0);

      // Backpressure: two reads fill the buffer, then drain in order.
      rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 5;
      #1;
      chk("bp_rd0", rd_ready, 1);
      cyc();
      rd_addr = 10;
      #1;
      chk("bp_rd1", rd_ready, 1);
      cyc();
      rd_addr = 12;
      #1;
      chk("bp_rd2_blocked", rd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      cyc();
      chk("bp_rd3_blocked", rd_ready, 0);
      chk_row("bp_head_hold", rsp_data, fill(8'hA5));
      cyc();
      rsp_ready = 1'b1;
      #1;
      chk("bp_resume0", rd_ready, 1);
      chk_row("bp_drain0", rsp_data, fill(8'hA5));
      cyc();
      rd_addr = 5;
      #1;
      chk("bp_resume1", rd_ready, 1);
      chk_row("bp_drain1", rsp_data, fill(8'h3C));
      cyc();
      rd_valid = 1'b0;
      #1;
      chk("bp_valid2", rsp_valid, 1);
      chk_row("bp_drain2", rsp_data, '0);
      cyc();
      chk_row("bp_drain3", rsp_data, fill(8'hA5));
      cyc();
      chk("bp_empty", rsp_valid, 0);

      // Partial strobe on row 3, read twice; then a zero-strobe write to row 5.
      wr_valid = 1'b1; wr_addr = 3; wr_data = fill(8'hFF); wr_strb = 1;
      #1;
      chk("p3_wstrb", mem_wstrb, 1);
      cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3;
      #1;
      chk("p3_b_valid", b_valid, 1);
      cyc();
      #1;
      chk("p3_rd_again", rd_ready, 1);
      cyc();
      rd_valid = 1'b0;
      #1;
      chk_row("p3_row_first", rsp_data, row3_exp);
      cyc();
      chk_row("p3_row_second", rsp_data, row3_exp);
      cyc();
      wr_valid = 1'b1; wr_addr = 5; wr_data = fill(8'h00); wr_strb = '0;
      #1;
      chk("z5_mem_we", mem_we, 1);
      chk("z5_wstrb", mem_wstrb, 0);
      cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5;
      #1;
      chk("z5_b_valid", b_valid, 1);
      cyc();
      rd_valid = 1'b0;
      cyc();
      chk_row("z5_row_unchanged", rsp_data, fill(8'hA5));
      cyc();

      // Reset one cycle after a read issue, with a completion stuck pending.
      b_ready = 1'b0; wr_valid = 1'b1; wr_addr = 20; wr_data = fill(8'h77); wr_strb = '1;
      cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10;
      #1;
      chk("mr_b_stuck", b_valid, 1);
      chk("mr_rd_issue", rd_ready, 1);
      cyc();
      rd_valid = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0; b_ready = 1'b1;
      #1;
      chk("mr_rsp_discarded", rsp_valid, 0);
      chk("mr_b_cleared", b_valid, 0);
      chk("mr_cs", mem_cs, 1);
      cyc();
      wr_valid = 1'b1; wr_addr = 21; wr_data = fill(8'h11); wr_strb = '1;
      rd_valid = 1'b1; rd_addr = 3;
      #1;
      chk("mr_tie_wr", wr_ready, 1);
      chk("mr_tie_rd", rd_ready, 0);
      cyc();
      wr_valid = 1'b0;
      #1;
      chk("mr_rd_issue2", rd_ready, 1);
      cyc();
      rd_valid = 1'b0;
      #1;
      chk("mr_rsp_t1", rsp_valid, 0);
      cyc();
      chk("mr_rsp_t2", rsp_valid, 1);
      chk_row("mr_rsp_data", rsp_data, row3_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
